ddfs_adsr: RTL

Envelope and sample-rate controller that sequences the DDFS datapath. It generates the per-sample `en` tick, with back-pressure from the downstream PCM FIFO. It also produces the Q2.14 `env` word through an attack/decay/sustain/release state machine driven by a note `gate`. It sits between the note/control registers and the `ddfs` instance, whose `en` and `env` inputs it drives directly.

---
 rtl/ddfs_pkg.sv | 14 +
 rtl/ddfs_adsr_if.sv | 29 ++
 rtl/ddfs_adsr_sample_tick.sv | 33 +++
 rtl/ddfs_adsr.sv | 104 ++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared types and constants for the DDFS envelope/sample-rate controller.
package ddfs_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  localparam logic [15:0] ENV_ONE = 16'h4000;

endpackage

// File: rtl/ddfs_adsr_if.sv
// Control/status bundle between the note registers and the envelope controller.
interface ddfs_adsr_if
  import ddfs_pkg::*;
#(
  parameter int DIV_WIDTH = 16
);
  logic                 gate;
  logic [DIV_WIDTH-1:0] sample_div;
  logic                 fifo_full;
  logic [15:0]          attack_step;
  logic [15:0]          decay_step;
  logic [15:0]          sustain_lvl;
  logic [15:0]          release_step;
  logic                 en;
  logic [15:0]          env;
  adsr_state_t          state;
  logic                 busy;
  logic                 note_done;

  modport master (
    output gate, sample_div, fifo_full, attack_step, decay_step, sustain_lvl, release_step,
    input  en, env, state, busy, note_done
  );

  modport slave (
    input  gate, sample_div, fifo_full, attack_step, decay_step, sustain_lvl, release_step,
    output en, env, state, busy, note_done
  );
endinterface

// File: rtl/ddfs_adsr_sample_tick.sv
// Sample-rate divider: one registered en pulse every sample_div+1 clocks,
// stalled (never dropped) while the downstream FIFO is full.
module sample_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic                 fifo_full,
  output logic                 en
);

  logic [DIV_WIDTH-1:0] cnt;

  // >= rather than == so a lowered sample_div can never strand cnt above it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      en  <= 1'b0;
    end else if (cnt >= sample_div) begin
      if (!fifo_full) begin
        cnt <= '0;
        en  <= 1'b1;
      end else begin
        en  <= 1'b0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      en  <= 1'b0;
    end
  end

endmodule

// File: rtl/ddfs_adsr.sv
// ADSR envelope FSM and sample tick generator driving the ddfs en/env inputs.
// state   | meaning
// IDLE    | no note, env held at 0
// ATTACK  | env rising by attack_step per tick up to ENV_ONE
// DECAY   | env falling by decay_step per tick down to sustain level
// SUSTAIN | env follows the (clamped) sustain level
// RELEASE | env falling by release_step per tick down to 0
module ddfs_adsr
  import ddfs_pkg::*;
#(
  parameter int          DIV_WIDTH = 16,
  parameter logic [15:0] ENV_ONE   = 16'h4000
) (
  input logic         clk,
  input logic         reset_n,
  ddfs_adsr_if.slave  bus
);

  logic        tick;
  adsr_state_t state_q;
  logic [15:0] env_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] sus;
  logic [16:0] att_sum;
  logic [16:0] dec_diff;
  logic [16:0] rel_diff;
  logic [15:0] att_val;
  logic [15:0] dec_val;
  logic [15:0] rel_val;

  sample_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_div (bus.sample_div),
    .fifo_full  (bus.fifo_full),
    .en         (tick)
  );

  // Saturating 17-bit arithmetic; a set bit 16 on a difference means it went negative
  always_comb begin
    sus      = (bus.sustain_lvl > ENV_ONE) ? ENV_ONE : bus.sustain_lvl;
    att_sum  = {1'b0, env_q} + {1'b0, bus.attack_step};
    dec_diff = {1'b0, env_q} - {1'b0, bus.decay_step};
    rel_diff = {1'b0, env_q} - {1'b0, bus.release_step};
    att_val  = (att_sum > {1'b0, ENV_ONE}) ? ENV_ONE : att_sum[15:0];
    dec_val  = (dec_diff[16] || (dec_diff[15:0] < sus)) ? sus : dec_diff[15:0];
    rel_val  = rel_diff[16] ? 16'h0000 : rel_diff[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      env_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      adsr_state_t nxt;
      nxt    = state_q;
      done_q <= 1'b0;

      if (tick) begin
        unique case (state_q)
          ATTACK: begin
            env_q <= att_val;
            if (att_val == ENV_ONE) nxt = DECAY;
          end
          DECAY: begin
            env_q <= dec_val;
            if (dec_val == sus) nxt = SUSTAIN;
          end
          SUSTAIN: env_q <= sus;
          RELEASE: begin
            env_q <= rel_val;
            if (rel_val == 16'h0000) begin
              nxt    = IDLE;
              done_q <= !bus.gate;
            end
          end
          default: env_q <= '0;
        endcase
      end

      // Gate edges override any level-driven move made above
      unique case (state_q)
        IDLE:                    if (bus.gate)  nxt = ATTACK;
        ATTACK, DECAY, SUSTAIN:  if (!bus.gate) nxt = RELEASE;
        RELEASE:                 if (bus.gate)  nxt = ATTACK;
        default:                 nxt = IDLE;
      endcase

      state_q <= nxt;
      busy_q  <= (nxt != IDLE);
    end
  end

  assign bus.en        = tick;
  assign bus.env       = env_q;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;
  assign bus.note_done = done_q;

endmodule
